// File: rtl/dpu_cmd_arbiter.sv
// dpu_cmd_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// command port into the core. A requester may hold the grant across several
// commands with its lock bit. Read commands wait for a single response byte,
// which is bounded by a timeout.

module dpu_cmd_arbiter #(
    parameter int          NUM_REQ   = 3,
    parameter int          ADDR_BITS = 24,
    parameter logic [2:0]  RD_TYPE   = 3'd4,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           s_cmd_valid,
    output logic [NUM_REQ-1:0]           s_cmd_ready,
    input  logic [3*NUM_REQ-1:0]         s_cmd_type,
    input  logic [ADDR_BITS*NUM_REQ-1:0] s_cmd_addr,
    input  logic [8*NUM_REQ-1:0]         s_cmd_data,
    input  logic [NUM_REQ-1:0]           s_cmd_lock,
    output logic [NUM_REQ-1:0]           s_rsp_valid,
    output logic [7:0]                   s_rsp_data,
    output logic                         m_cmd_valid,
    input  logic                         m_cmd_ready,
    output logic [2:0]                   m_cmd_type,
    output logic [ADDR_BITS-1:0]         m_cmd_addr,
    output logic [7:0]                   m_cmd_data,
    input  logic                         m_rsp_valid,
    input  logic [7:0]                   m_rsp_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_RSP
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDXW-1:0]     r_grantIdx;
    logic [IDXW-1:0]     r_lastGrant;
    logic [CNTW-1:0]     r_count;
    logic [NUM_REQ-1:0]  r_rspValid;
    logic [7:0]          r_rspData;
    logic                r_timeoutErr;

    logic [IDXW-1:0]     w_winIdx;
    logic [IDXW-1:0]     w_candIdx;
    logic                w_found;
    logic                w_selValid;
    logic                w_selLock;
    logic [2:0]          w_selType;
    logic                w_handshake;

    // Round-robin search: first valid requester after the last owner, wrapping.
    always_comb begin
        w_winIdx  = '0;
        w_candIdx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found) begin
                w_candIdx = IDXW'((int'(r_lastGrant) + k) % NUM_REQ);
                if (s_cmd_valid[w_candIdx]) begin
                    w_winIdx = w_candIdx;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign w_selValid  = s_cmd_valid[r_grantIdx];
    assign w_selLock   = s_cmd_lock[r_grantIdx];
    assign w_selType   = s_cmd_type[r_grantIdx*3 +: 3];
    assign w_handshake = (r_state == GRANT) && w_selValid && m_cmd_ready;

    assign m_cmd_valid = (r_state == GRANT) && w_selValid;
    assign s_cmd_ready = ((r_state == GRANT) && m_cmd_ready) ? r_grant : '0;
    assign m_cmd_type  = w_selType;
    assign m_cmd_addr  = s_cmd_addr[r_grantIdx*ADDR_BITS +: ADDR_BITS];
    assign m_cmd_data  = s_cmd_data[r_grantIdx*8 +: 8];
    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeoutErr;
    assign s_rsp_valid = r_rspValid;
    assign s_rsp_data  = r_rspData;

    // Arbitration FSM; grant only moves in IDLE so lock bursts cannot be pre-empted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grantIdx   <= '0;
            r_lastGrant  <= LAST_IDX;
            r_count      <= '0;
            r_rspValid   <= '0;
            r_rspData    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_rspValid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant    <= NUM_REQ'(1) << w_winIdx;
                        r_grantIdx <= w_winIdx;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_handshake) begin
                        if (w_selType == RD_TYPE) begin
                            r_state <= WAIT_RSP;
                            r_count <= '0;
                        end else if (!w_selLock) begin
                            r_state     <= IDLE;
                            r_grant     <= '0;
                            r_lastGrant <= r_grantIdx;
                        end
                    end else if (!w_selValid && !w_selLock) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_lastGrant <= r_grantIdx;
                    end
                end
                WAIT_RSP: begin
                    if (m_rsp_valid) begin
                        r_rspValid <= r_grant;
                        r_rspData  <= m_rsp_data;
                        if (w_selLock) begin
                            r_state <= GRANT;
                        end else begin
                            r_state     <= IDLE;
                            r_grant     <= '0;
                            r_lastGrant <= r_grantIdx;
                        end
                    end else if (r_count >= CNT_LIMIT) begin
                        r_timeoutErr <= 1'b1;
                        r_rspValid   <= r_grant;
                        r_rspData    <= 8'h00;
                        r_state      <= IDLE;
                        r_grant      <= '0;
                        r_lastGrant  <= r_grantIdx;
                    end else if (r_count != CNT_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpu_cmd_arbiter.sv
// tb_dpu_cmd_arbiter: directed bench for dpu_cmd_arbiter with three requesters
// and a short timeout. Each step drives inputs just after a rising edge and
// compares outputs against hand-computed values.

module tb_dpu_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  s_cmd_valid;
    logic [2:0]  s_cmd_ready;
    logic [8:0]  s_cmd_type;
    logic [71:0] s_cmd_addr;
    logic [23:0] s_cmd_data;
    logic [2:0]  s_cmd_lock;
    logic [2:0]  s_rsp_valid;
    logic [7:0]  s_rsp_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [2:0]  m_cmd_type;
    logic [23:0] m_cmd_addr;
    logic [7:0]  m_cmd_data;
    logic        m_rsp_valid;
    logic [7:0]  m_rsp_data;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout_err;

    int vectors;
    int miscompares;
    int hsCount;
    int expOrder[4] = '{0, 1, 2, 0};

    dpu_cmd_arbiter #(
        .NUM_REQ   (3),
        .ADDR_BITS (24),
        .RD_TYPE   (3'd4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_ready (s_cmd_ready),
        .s_cmd_type  (s_cmd_type),
        .s_cmd_addr  (s_cmd_addr),
        .s_cmd_data  (s_cmd_data),
        .s_cmd_lock  (s_cmd_lock),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_data  (s_rsp_data),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_cmd_type  (m_cmd_type),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_data  (m_cmd_data),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [2:0] t,
                                 input logic [23:0] a, input logic [7:0] d, input logic l);
        s_cmd_valid[i]          = v;
        s_cmd_type[3*i +: 3]    = t;
        s_cmd_addr[24*i +: 24]  = a;
        s_cmd_data[8*i +: 8]    = d;
        s_cmd_lock[i]           = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_grant"},   32'(grant), 32'h0);
        checkOutput({tag, "_busy"},    32'(busy), 32'h0);
        checkOutput({tag, "_rspv"},    32'(s_rsp_valid), 32'h0);
        checkOutput({tag, "_rspd"},    32'(s_rsp_data), 32'h0);
        checkOutput({tag, "_tmo"},     32'(timeout_err), 32'h0);
        checkOutput({tag, "_mvalid"},  32'(m_cmd_valid), 32'h0);
        checkOutput({tag, "_sready"},  32'(s_cmd_ready), 32'h0);
    endtask

    // Directed scenario sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        s_cmd_valid = '0;
        s_cmd_type  = '0;
        s_cmd_addr  = '0;
        s_cmd_data  = '0;
        s_cmd_lock  = '0;
        m_cmd_ready = 1'b1;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        repeat (3) tick();
        checkResetState("reset");

        // Round robin 0,1,2,0 with an IDLE cycle between grants
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 3'd1, 24'h100 + 24'(i), 8'h10 + 8'(i), 1'b0);
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput("rr_grant",  32'(grant), 32'(1) << expOrder[n]);
            checkOutput("rr_addr",   32'(m_cmd_addr), 32'h100 + 32'(expOrder[n]));
            checkOutput("rr_ready",  32'(s_cmd_ready), 32'(1) << expOrder[n]);
            tick();
            checkOutput("rr_idle_grant", 32'(grant), 32'h0);
            checkOutput("rr_idle_busy",  32'(busy), 32'h0);
            if (n == 3) s_cmd_valid = '0;
        end

        // Locked burst of four commands from requester 1 while 0 waits
        applyStimulus(0, 1'b1, 3'd1, 24'h200, 8'hA0, 1'b0);
        applyStimulus(1, 1'b1, 3'd1, 24'h210, 8'hB0, 1'b1);
        tick();
        hsCount = 0;
        for (int n = 0; n < 4; n++) begin
            s_cmd_data[15:8] = 8'hB0 + 8'(n);
            if (n == 3) s_cmd_lock[1] = 1'b0;
            #1;
            checkOutput("lock_grant", 32'(grant), 32'h2);
            checkOutput("lock_data",  32'(m_cmd_data), 32'hB0 + 32'(n));
            if (m_cmd_valid && m_cmd_ready) hsCount++;
            tick();
        end
        checkOutput("lock_hs_count", 32'(hsCount), 32'd4);
        checkOutput("lock_release",  32'(grant), 32'h0);
        s_cmd_valid[1] = 1'b0;
        tick();
        checkOutput("lock_next_grant", 32'(grant), 32'h1);
        checkOutput("lock_next_addr",  32'(m_cmd_addr), 32'h200);
        tick();
        s_cmd_valid[0] = 1'b0;
        checkOutput("lock_next_idle", 32'(grant), 32'h0);

        // Read from requester 2, response 0x5A four cycles after handshake
        applyStimulus(2, 1'b1, 3'd4, 24'h000123, 8'h00, 1'b0);
        tick();
        checkOutput("rd_grant", 32'(grant), 32'h4);
        checkOutput("rd_type",  32'(m_cmd_type), 32'h4);
        checkOutput("rd_addr",  32'(m_cmd_addr), 32'h000123);
        tick();
        s_cmd_valid[2] = 1'b0;
        checkOutput("rd_wait_busy",   32'(busy), 32'h1);
        checkOutput("rd_wait_mvalid", 32'(m_cmd_valid), 32'h0);
        checkOutput("rd_wait_sready", 32'(s_cmd_ready), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("rd_wait_rspv", 32'(s_rsp_valid), 32'h0);
        end
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'h5A;
        tick();
        m_rsp_valid = 1'b0;
        checkOutput("rd_rspv",  32'(s_rsp_valid), 32'h4);
        checkOutput("rd_rspd",  32'(s_rsp_data), 32'h5A);
        checkOutput("rd_idle",  32'(busy), 32'h0);
        checkOutput("rd_tmo",   32'(timeout_err), 32'h0);
        tick();
        checkOutput("rd_rspv_pulse", 32'(s_rsp_valid), 32'h0);

        // Core stalls for 10 cycles; a stray response must be ignored
        m_cmd_ready = 1'b0;
        applyStimulus(0, 1'b1, 3'd2, 24'hABCDEF, 8'h77, 1'b0);
        tick();
        checkOutput("stall_grant", 32'(grant), 32'h1);
        for (int n = 0; n < 10; n++) begin
            checkOutput("stall_mvalid", 32'(m_cmd_valid), 32'h1);
            checkOutput("stall_sready", 32'(s_cmd_ready), 32'h0);
            checkOutput("stall_fields", {5'h0, m_cmd_type, m_cmd_addr}, {5'h0, 3'd2, 24'hABCDEF});
            checkOutput("stall_rspv",   32'(s_rsp_valid), 32'h0);
            if (n == 3) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = 8'hEE;
            end
            if (n == 6) m_rsp_valid = 1'b0;
            tick();
        end
        checkOutput("stall_rspd_kept", 32'(s_rsp_data), 32'h5A);
        m_cmd_ready = 1'b1;
        #1;
        checkOutput("stall_ready_on", 32'(s_cmd_ready), 32'h1);
        tick();
        s_cmd_valid[0] = 1'b0;
        checkOutput("stall_done_busy", 32'(busy), 32'h0);

        // Response arriving exactly on the last count is a real response
        applyStimulus(1, 1'b1, 3'd4, 24'h000456, 8'h00, 1'b0);
        tick();
        checkOutput("edge_grant", 32'(grant), 32'h2);
        tick();
        s_cmd_valid[1] = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            checkOutput("edge_wait_busy", 32'(busy), 32'h1);
            checkOutput("edge_wait_rspv", 32'(s_rsp_valid), 32'h0);
        end
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'hC3;
        tick();
        m_rsp_valid = 1'b0;
        checkOutput("edge_rspv", 32'(s_rsp_valid), 32'h2);
        checkOutput("edge_rspd", 32'(s_rsp_data), 32'hC3);
        checkOutput("edge_tmo",  32'(timeout_err), 32'h0);
        checkOutput("edge_busy", 32'(busy), 32'h0);

        // No response: timeout on the 16th wait cycle
        applyStimulus(1, 1'b1, 3'd4, 24'h000789, 8'h00, 1'b0);
        tick();
        checkOutput("tmo_grant", 32'(grant), 32'h2);
        tick();
        s_cmd_valid[1] = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            checkOutput("tmo_wait_err",  32'(timeout_err), 32'h0);
            checkOutput("tmo_wait_busy", 32'(busy), 32'h1);
        end
        tick();
        checkOutput("tmo_err",   32'(timeout_err), 32'h1);
        checkOutput("tmo_rspv",  32'(s_rsp_valid), 32'h2);
        checkOutput("tmo_rspd",  32'(s_rsp_data), 32'h00);
        checkOutput("tmo_busy",  32'(busy), 32'h0);
        checkOutput("tmo_grant0", 32'(grant), 32'h0);
        tick();
        checkOutput("tmo_sticky", 32'(timeout_err), 32'h1);
        checkOutput("tmo_pulse",  32'(s_rsp_valid), 32'h0);

        // Reset during WAIT_RSP with a response arriving the same cycle
        applyStimulus(0, 1'b1, 3'd4, 24'h000ABC, 8'h00, 1'b0);
        tick();
        checkOutput("rstw_grant", 32'(grant), 32'h1);
        tick();
        s_cmd_valid[0] = 1'b0;
        tick();
        rst         = 1'b1;
        m_rsp_valid = 1'b1;
        m_rsp_data  = 8'h99;
        tick();
        checkResetState("rstw");
        rst         = 1'b0;
        m_rsp_valid = 1'b0;
        tick();
        checkOutput("rstw_after_rspv", 32'(s_rsp_valid), 32'h0);

        // Last owner restored by reset: requester 0 wins among all three
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 3'd1, 24'h300 + 24'(i), 8'h00, 1'b0);
        tick();
        checkOutput("rstw_first_grant", 32'(grant), 32'h1);
        tick();
        s_cmd_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
